// File: rtl/sa_pkg.sv
// Shared types and helpers for the weight-stationary systolic array.
package sa_pkg;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StLoad  = 2'd1,
      StRun   = 2'd2,
      StDrain = 2'd3
   } sa_state_e;

   // Ceiling log2 that never returns 0, so counters sized from it stay legal.
   function automatic int unsigned sa_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/sa_pe.sv
// One weight-stationary cell: holds a weight, forwards the activation right
// and the accumulated partial sum down.
module sa_pe #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 18
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_w_en,
   input  logic signed [DW-1:0] i_w,
   output logic signed [DW-1:0] o_w,
   input  logic signed [DW-1:0] i_a,
   output logic signed [DW-1:0] o_a,
   input  logic signed [AW-1:0] i_psum,
   output logic signed [AW-1:0] o_psum
);

   logic signed [DW-1:0]   r_w;
   logic signed [DW-1:0]   r_a;
   logic signed [AW-1:0]   r_psum;
   logic signed [2*DW-1:0] w_prod;

   assign w_prod = (2*DW)'(i_a) * (2*DW)'(r_w);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_w    <= '0;
         r_a    <= '0;
         r_psum <= '0;
      end else begin
         if (i_w_en) r_w <= i_w;
         r_a    <= i_a;
         r_psum <= i_psum + AW'(w_prod);
      end
   end

   assign o_w    = r_w;
   assign o_a    = r_a;
   assign o_psum = r_psum;

endmodule

// File: rtl/sa_array.sv
// Parametrised weight-stationary systolic array y = a^T * W with runtime weight
// loading, built-in input skew / output deskew and a drain-before-reload FSM.
module sa_array
   import sa_pkg::*;
#(
   parameter int unsigned ROWS = 2,
   parameter int unsigned COLS = 2,
   parameter int unsigned DW   = 8,
   parameter int unsigned AW   = 2*DW + $clog2(ROWS) + 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_w_valid,
   output logic               o_w_ready,
   input  logic [COLS*DW-1:0] i_w_data,
   input  logic               i_a_valid,
   output logic               o_a_ready,
   input  logic [ROWS*DW-1:0] i_a_data,
   output logic               o_y_valid,
   output logic [COLS*AW-1:0] o_y_data
);

   localparam int unsigned L  = ROWS + COLS;
   localparam int unsigned BW = sa_clog2(ROWS);
   localparam int unsigned CW = sa_clog2(L + 2);

   localparam logic [1:0] S_EMPTY = StEmpty;
   localparam logic [1:0] S_LOAD  = StLoad;
   localparam logic [1:0] S_RUN   = StRun;
   localparam logic [1:0] S_DRAIN = StDrain;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [BW-1:0] r_beat;
   logic [BW-1:0] w_beat_nxt;
   logic [CW-1:0] r_infl;
   logic [CW-1:0] w_infl_nxt;
   logic [L:0]    r_tag;
   logic          w_w_acc;
   logic          w_a_acc;

   logic signed [DW-1:0] w_a  [ROWS][COLS+1];
   logic signed [DW-1:0] w_wt [ROWS+1][COLS];
   logic signed [AW-1:0] w_ps [ROWS+1][COLS];
   logic [ROWS*DW-1:0]   w_unused_a;
   logic [COLS*DW-1:0]   w_unused_w;

   assign o_w_ready = (r_state == S_EMPTY) || (r_state == S_LOAD);
   assign o_a_ready = (r_state == S_RUN);
   assign w_w_acc   = i_w_valid && o_w_ready;
   assign w_a_acc   = i_a_valid && o_a_ready;
   assign o_y_valid = r_tag[L];

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      unique case (r_state)
         S_EMPTY, S_LOAD: begin
            if (w_w_acc) begin
               if (r_beat == BW'(ROWS - 1)) begin
                  w_state_nxt = S_RUN;
                  w_beat_nxt  = '0;
               end else begin
                  w_state_nxt = S_LOAD;
                  w_beat_nxt  = r_beat + BW'(1);
               end
            end
         end
         S_RUN: begin
            if (i_w_valid) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_infl == '0) begin
               w_state_nxt = S_LOAD;
               w_beat_nxt  = '0;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_comb begin
      w_infl_nxt = r_infl;
      if (w_a_acc && !o_y_valid) begin
         w_infl_nxt = r_infl + CW'(1);
      end else if (!w_a_acc && o_y_valid) begin
         w_infl_nxt = r_infl - CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_EMPTY;
         r_beat  <= '0;
         r_infl  <= '0;
         r_tag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         r_infl  <= w_infl_nxt;
         r_tag   <= {r_tag[L-1:0], w_a_acc};
      end
   end

   // Row r sees its activation r cycles after the common capture stage.
   for (genvar gr = 0; gr < ROWS; gr++) begin : g_skew
      logic signed [DW-1:0] r_sk [gr+1];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int i = 0; i <= gr; i++) r_sk[i] <= '0;
         end else begin
            r_sk[0] <= w_a_acc ? i_a_data[gr*DW +: DW] : '0;
            for (int i = 1; i <= gr; i++) r_sk[i] <= r_sk[i-1];
         end
      end

      assign w_a[gr][0] = r_sk[gr];
      assign w_unused_a[gr*DW +: DW] = w_a[gr][COLS];
   end

   // Column c waits COLS-1-c cycles plus one output stage so all columns align.
   for (genvar gc = 0; gc < COLS; gc++) begin : g_deskew
      localparam int unsigned D = COLS - 1 - gc;
      logic signed [AW-1:0] r_dk [D+1];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int i = 0; i <= D; i++) r_dk[i] <= '0;
         end else begin
            r_dk[0] <= w_ps[ROWS][gc];
            for (int i = 1; i <= D; i++) r_dk[i] <= r_dk[i-1];
         end
      end

      assign o_y_data[gc*AW +: AW]    = r_dk[D];
      assign w_wt[0][gc]              = i_w_data[gc*DW +: DW];
      assign w_ps[0][gc]              = '0;
      assign w_unused_w[gc*DW +: DW] = w_wt[ROWS][gc];
   end

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < COLS; gc++) begin : g_col
         sa_pe #(
            .DW (DW),
            .AW (AW)
         ) u_pe (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_w_en  (w_w_acc),
            .i_w     (w_wt[gr][gc]),
            .o_w     (w_wt[gr+1][gc]),
            .i_a     (w_a[gr][gc]),
            .o_a     (w_a[gr][gc+1]),
            .i_psum  (w_ps[gr][gc]),
            .o_psum  (w_ps[gr+1][gc])
         );
      end
   end

endmodule

// File: tb/tb_sa_array.sv
// Directed bench for the 2x2 systolic array: reset, load, streaming, reload,
// signed extremes and mid-stream reset, checked with immediate assertions.
module tb_sa_array;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        w_valid = 1'b0;
   logic        a_valid = 1'b0;
   logic [15:0] w_data  = '0;
   logic [15:0] a_data  = '0;
   logic        w_ready;
   logic        a_ready;
   logic        y_valid;
   logic [35:0] y_data;

   int checks   = 0;
   int failures = 0;

   logic        s_vld [8];
   logic [15:0] s_a   [8];
   logic [35:0] e_y   [8];

   always #5 clk = ~clk;

   sa_array #(
      .ROWS (2),
      .COLS (2),
      .DW   (8)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_w_valid (w_valid),
      .o_w_ready (w_ready),
      .i_w_data  (w_data),
      .i_a_valid (a_valid),
      .o_a_ready (a_ready),
      .i_a_data  (a_data),
      .o_y_valid (y_valid),
      .o_y_data  (y_data)
   );

   function automatic logic [15:0] av(input int a0, input int a1);
      return {8'(a1), 8'(a0)};
   endfunction

   function automatic logic [35:0] yv(input int y0, input int y1);
      return {18'(y1), 18'(y0)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_slots();
      for (int i = 0; i < 8; i++) begin
         s_vld[i] = 1'b0;
         s_a[i]   = '0;
         e_y[i]   = '0;
      end
   endtask

   task automatic slot(input int i, input int a0, input int a1, input int y0, input int y1);
      s_vld[i] = 1'b1;
      s_a[i]   = av(a0, a1);
      e_y[i]   = yv(y0, y1);
   endtask

   // Drive 8 slots on consecutive cycles; each result is due 4 edges later.
   task automatic stream(input string tag);
      chk({tag, "_ardy"}, a_ready, 1);
      for (int j = 0; j < 12; j++) begin
         if (j < 8) begin
            a_valid = s_vld[j];
            a_data  = s_a[j];
         end else begin
            a_valid = 1'b0;
            a_data  = '0;
         end
         @(negedge clk);
         if (j >= 4) begin
            chk({tag, "_vld"}, y_valid, s_vld[j-4]);
            if (s_vld[j-4]) chk({tag, "_y"}, y_data, e_y[j-4]);
         end else begin
            chk({tag, "_early"}, y_valid, 0);
         end
      end
      a_valid = 1'b0;
   endtask

   task automatic load_w(input string tag, input logic [15:0] b0, input logic [15:0] b1);
      int n;
      n       = 0;
      w_valid = 1'b1;
      w_data  = b0;
      while (w_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_wrdy"}, w_ready, 1);
      @(negedge clk);
      w_data = b1;
      @(negedge clk);
      w_valid = 1'b0;
      w_data  = '0;
      chk({tag, "_run"}, a_ready, 1);
   endtask

   initial begin
      // Reset with busy inputs
      a_valid = 1'b1;
      w_valid = 1'b1;
      a_data  = 16'hA5C3;
      w_data  = 16'h5A3C;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_yvld", y_valid, 0);
      chk("rst_ydata", y_data, 0);
      chk("rst_ardy", a_ready, 0);
      chk("rst_wrdy", w_ready, 1);
      a_valid = 1'b0;
      w_valid = 1'b0;
      a_data  = '0;
      w_data  = '0;
      rst_n   = 1'b1;
      @(negedge clk);

      // Load W=[[1,2],[3,4]] with a gap between the beats
      w_valid = 1'b1;
      w_data  = av(3, 4);
      @(negedge clk);
      w_valid = 1'b0;
      w_data  = av(9, 9);
      @(negedge clk);
      chk("gap_wrdy", w_ready, 1);
      chk("gap_ardy", a_ready, 0);
      w_valid = 1'b1;
      w_data  = av(1, 2);
      @(negedge clk);
      w_valid = 1'b0;
      w_data  = '0;
      chk("load_ardy", a_ready, 1);
      chk("load_wrdy", w_ready, 0);

      clr_slots();
      slot(0, 5, 6, 23, 34);
      stream("single");

      clr_slots();
      slot(0, 1, 0, 1, 2);
      slot(1, 0, 1, 3, 4);
      slot(2, -1, -1, -4, -6);
      stream("b2b");

      clr_slots();
      slot(0, 5, 6, 23, 34);
      slot(2, 2, -1, -1, 0);
      slot(5, -3, 2, 3, 2);
      slot(6, 10, 10, 40, 60);
      stream("bubble");

      // Reload requested one cycle after two accepts
      a_valid = 1'b1;
      a_data  = av(1, 1);
      @(negedge clk);
      a_data  = av(2, 0);
      @(negedge clk);
      a_valid = 1'b0;
      a_data  = '0;
      w_valid = 1'b1;
      w_data  = av(0, 1);
      for (int j = 2; j <= 5; j++) begin
         @(negedge clk);
         if (j == 2) chk("rl_ardy", a_ready, 0);
         chk("rl_wrdy_hold", w_ready, 0);
         if (j == 4) begin
            chk("rl_old0_vld", y_valid, 1);
            chk("rl_old0_y", y_data, yv(4, 6));
         end
         if (j == 5) begin
            chk("rl_old1_vld", y_valid, 1);
            chk("rl_old1_y", y_data, yv(2, 4));
         end
      end
      load_w("rl", av(0, 1), av(1, 0));
      clr_slots();
      slot(0, 7, -9, 7, -9);
      stream("ident");

      // Signed extremes
      load_w("ext", av(-128, -128), av(-128, -128));
      clr_slots();
      slot(0, -128, -128, 32768, 32768);
      stream("ext");

      // Reset while results are in flight
      a_valid = 1'b1;
      a_data  = av(1, 1);
      @(negedge clk);
      a_data  = av(2, 2);
      @(negedge clk);
      a_valid = 1'b0;
      a_data  = '0;
      repeat (3) @(negedge clk);
      chk("mid_vld", y_valid, 1);
      chk("mid_y", y_data, yv(-256, -256));
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", y_valid, 0);
      chk("mid_rst_y", y_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk("post_rst_vld", y_valid, 0);
      end
      chk("post_rst_ardy", a_ready, 0);
      chk("post_rst_wrdy", w_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sa_array.md
# sa_array

Parametrised weight-stationary systolic array computing y = aᵀ·W for a ROWS×COLS signed weight matrix W. It generalises the fixed 2×2 array to arbitrary dimensions, adds runtime weight loading, and uses valid/ready handshakes on the input side. Internal input skew and output deskew are built in, so callers present and receive whole aligned vectors. It sits between the activation buffer and the accumulator/requantisation stage of the accelerator datapath.

## Interface
- ROWS, 2, number of PE rows (activation vector length), ≥1
- COLS, 2, number of PE columns (output vector length), ≥1
- DW, 8, signed width of activations and weights
- AW, 2*DW+$clog2(ROWS)+1, signed accumulator/output width
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- w_valid  in  1  weight row beat valid
- w_ready  out  1  array accepts a weight beat
- w_data  in  COLS*DW  one weight row; element c at [c*DW +: DW]
- a_valid  in  1  activation vector valid
- a_ready  out  1  array accepts an activation vector
- a_data  in  ROWS*DW  activation vector; element r at [r*DW +: DW]
- y_valid  out  1  result vector valid (single-cycle; no backpressure)
- y_data  out  COLS*AW  result; element c at [c*AW +: AW]

## Operation
- FSM states: EMPTY, LOAD, RUN, DRAIN.
  - EMPTY: entered on reset; holds no valid weights.
  - LOAD: weight rows are being shifted in.
  - RUN: activations are accepted.
  - DRAIN: waits for the pipeline to empty before a reload.
- Handshake signals are Moore outputs of the state:
  - w_ready=1 in EMPTY and LOAD only.
  - a_ready=1 in RUN only.
- Transitions:
  - EMPTY→LOAD on w_valid; that beat counts as beat 0.
  - LOAD→RUN after the ROWS-th accepted beat.
  - RUN→DRAIN when w_valid=1. The activation handshake in that same cycle is still honoured.
  - DRAIN→LOAD when the in-flight count is 0. Beat counter resets to 0.
- Weight load:
  - Each accepted beat shifts all weight rows down by one and writes w_data into row 0.
  - After ROWS beats, row r holds beat ROWS-1-r.
  - A w_valid gap during LOAD leaves the state and beat count unchanged.
- Compute:
  - y[c] = Σ_r a[r]·W[r][c], signed, sign-extended to AW.
  - If AW is set below the default, results wrap modulo 2^AW. No saturation.
  - With the default AW, no overflow is possible.
- Dataflow:
  - Activation element r is delayed r cycles, then enters row r and passes rightward through the columns.
  - Partial sums flow downward through the rows.
  - Column c output is delayed COLS-1-c cycles so all elements emerge together.
  - A valid tag travels with the data, so bubbles produce y_valid=0 at the corresponding cycle.
- The in-flight counter increments on an activation handshake and decrements on y_valid.
- Reset (asserted at any time, including mid-load or mid-stream):
  - All registers clear immediately: weights 0, pipeline and tags 0, state EMPTY.
  - y_valid and y_data go to 0. No stale result appears after release.

## Timing
- Reset values:
  - y_valid=0, y_data=0.
  - a_ready=0, w_ready=1 (state EMPTY).
- Latency L = ROWS+COLS edges. A vector accepted on edge k produces y_valid=1 in the cycle following edge k+L, for exactly one cycle.
- Throughput: one vector per cycle in RUN. Consecutive accepts give consecutive results.
- Weight changes take effect only for vectors accepted after re-entering RUN. In-flight vectors always complete with the old weights, guaranteed by DRAIN.
- Minimum reload gap: DRAIN takes ≤L cycles, then ROWS load beats.

## Structure
- Package sa_pkg:
  - state enum typedef (EMPTY/LOAD/RUN/DRAIN)
  - clog2-safe helper function
- Sub-module sa_pe: one weight-stationary cell.
  - Holds a weight register with shift-in enable.
  - Registers the activation (passed right) and the partial sum (passed down): psum_out <= psum_in + a·w.
- Top level contains: ROWS×COLS generate grid, skew and deskew shift registers, valid-tag pipeline, FSM, beat counter, in-flight counter.

## Test plan
- Reset: hold rst=0 with random inputs → y_valid=0, y_data=0, a_ready=0, w_ready=1. Assert mid-stream → y_valid drops immediately; nothing appears after release.
- Load and single vector (ROWS=COLS=2, DW=8):
  - Load beats [3,4] then [1,2], giving W=[[1,2],[3,4]].
  - Send a=[5,6].
  - → y=[23,34] exactly 4 edges after acceptance.
- Back-to-back with W as above:
  - Send a=[1,0], [0,1], [-1,-1] on consecutive cycles.
  - → y=[1,2], [3,4], [-4,-6] on consecutive cycles.
- Signed extremes:
  - All weights -128, a=[-128,-128].
  - → y=[32768,32768] with default AW=18. No wrap.
- Reload during streaming:
  - Assert w_valid one cycle after two activation accepts.
  - → a_ready=0 next cycle.
  - → Both old results emerge correct, then w_ready=1.
  - → After loading identity, a=[7,-9] gives y=[7,-9].
- Bubbles and partial load:
  - Insert a_valid gaps → y_valid gaps mirror them with latency 4.
  - A w_valid gap mid-load → state stays LOAD, and the loaded W is still correct.
